// File: rtl/led_fnd_axi_slave_if.sv
// AXI4-Lite bus bundle for the led_fnd S00_AXI endpoint.
interface led_fnd_axi_slave_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) ();

  // Write address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                      awprot;
  logic                            awvalid;
  logic                            awready;
  // Write data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                            wvalid;
  logic                            wready;
  // Write response channel
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  // Read address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                      arprot;
  logic                            arvalid;
  logic                            arready;
  // Read data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/led_fnd_axi_slave.sv
// AXI4-Lite register slave driving an LED bank and a 4-digit multiplexed
// common-anode 7-segment display. Four 32-bit R/W registers selected by addr[3:2].
module led_fnd_axi_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned LED_WIDTH          = 8,
  parameter int unsigned SCAN_DIV           = 100000
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  led_fnd_axi_slave_if.slave   s00_axi,
  output logic [LED_WIDTH-1:0] led,
  output logic [7:0]           fnd_seg,
  output logic [3:0]           fnd_com
);

  localparam int unsigned NumLanes = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {WIdle, WAck, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAck, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]      rdata_q, rdata_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      com_q, com_d;
  logic [7:0]      seg_q, seg_d;

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_w, araddr_w;
  logic [1:0] widx, ridx;
  logic awready_w, wready_w, bvalid_w, arready_w, rvalid_w;

  assign awaddr_w = s00_axi.awaddr;
  assign araddr_w = s00_axi.araddr;
  assign widx     = awaddr_w[3:2];
  assign ridx     = araddr_w[3:2];

  // Protection bits and low/high address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi.awprot, s00_axi.arprot, awaddr_w, araddr_w};

  // Hex digit to active-low segments, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Write FSM: accept only when address and data arrive together.
  always_comb begin
    w_state_d = w_state_q;
    awready_w = 1'b0;
    wready_w  = 1'b0;
    bvalid_w  = 1'b0;
    unique case (w_state_q)
      WIdle: if (s00_axi.awvalid && s00_axi.wvalid) w_state_d = WAck;
      WAck: begin
        awready_w = 1'b1;
        wready_w  = 1'b1;
        w_state_d = WResp;
      end
      WResp: begin
        bvalid_w = 1'b1;
        if (s00_axi.bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read FSM: independent of the write side.
  always_comb begin
    r_state_d = r_state_q;
    arready_w = 1'b0;
    rvalid_w  = 1'b0;
    unique case (r_state_q)
      RIdle: if (s00_axi.arvalid) r_state_d = RAck;
      RAck: begin
        arready_w = 1'b1;
        r_state_d = RData;
      end
      RData: begin
        rvalid_w = 1'b1;
        if (s00_axi.rready) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Register file update with per-byte strobes during the accept cycle.
  always_comb begin
    regs_d = regs_q;
    if (w_state_q == WAck) begin
      for (int b = 0; b < NumLanes; b++) begin
        if (s00_axi.wstrb[b]) regs_d[widx][8*b +: 8] = s00_axi.wdata[8*b +: 8];
      end
    end
  end

  // Read data capture; samples regs_q so a same-edge write is not visible.
  always_comb begin
    rdata_d = rdata_q;
    if (r_state_q == RAck) rdata_d = regs_q[ridx];
  end

  // Scan counter and digit index; keeps running while the display is off.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Display drive for the current digit; blanked when fnd_en is low.
  always_comb begin
    com_d = 4'hF;
    seg_d = 8'hFF;
    if (regs_q[2][0]) begin
      com_d = ~(4'b0001 << idx_q);
      seg_d = {~regs_q[2][4 + idx_q], hex7(regs_q[1][{idx_q, 2'b00} +: 4])};
    end
  end

  // State and storage registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      regs_q    <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      com_q     <= 4'hF;
      seg_q     <= 8'hFF;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      regs_q    <= regs_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      com_q     <= com_d;
      seg_q     <= seg_d;
    end
  end

  assign s00_axi.awready = awready_w;
  assign s00_axi.wready  = wready_w;
  assign s00_axi.bvalid  = bvalid_w;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = arready_w;
  assign s00_axi.rvalid  = rvalid_w;
  assign s00_axi.rresp   = 2'b00;
  assign s00_axi.rdata   = rdata_q;

  assign led     = regs_q[0][LED_WIDTH-1:0];
  assign fnd_com = com_q;
  assign fnd_seg = seg_q;

endmodule

// File: doc/led_fnd_axi_slave.md
# led_fnd_axi_slave

AXI4-Lite slave (responder) for the LED/FND peripheral: accepts single-beat register writes and reads from the PS or AXI VIP master. It exposes four 32-bit read/write registers and drives an LED bank plus a 4-digit multiplexed common-anode 7-segment (FND) display. It sits behind the AXI interconnect as the S00_AXI endpoint of the led_fnd IP.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
- LED_WIDTH, 8, number of LED outputs (1..32).
- SCAN_DIV, 100000, clocks per FND digit slot (≥2).
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  reset, asynchronous, active-low.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  ADDR/3/1/1  write address channel; awprot ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  ADDR/3/1/1  read address; arprot ignored.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data.
- led  out  LED_WIDTH  active-high LED drive.
- fnd_seg  out  8  active-low segments; [6:0]=g..a, [7]=dp.
- fnd_com  out  4  active-low digit enables, one-hot-low.

## Operation
- Register map (addr[3:2]); all 32 bits are stored and read back exactly:
  - 0x0 REG_LED: led = REG_LED[LED_WIDTH-1:0].
  - 0x4 REG_FND: digit k shows hex nibble REG_FND[4k+3:4k]; digit 0 is the rightmost.
  - 0x8 REG_CTRL: bit0 fnd_en; bits[7:4] dp mask (bit 4+k lights the dp of digit k); other bits are storage only.
  - 0xC REG_SCRATCH: pure storage.
- Address bits [1:0] and above bit 3 are ignored; there is no decode error. bresp and rresp are always 2'b00 (OKAY).
- WSTRB: byte lane b is written only when wstrb[b]=1. wstrb=0 completes the handshake but writes nothing.
- Write FSM: W_IDLE → W_ACK → W_RESP → W_IDLE.
  - W_IDLE: waits for awvalid & wvalid both high.
  - W_ACK: awready=wready=1 for exactly 1 cycle; register written at the end of this cycle.
  - W_RESP: bvalid=1, held until bready.
  - awvalid alone or wvalid alone is never accepted.
- Read FSM: R_IDLE → R_ACK → R_DATA → R_IDLE.
  - R_ACK: arready=1 for 1 cycle; rdata latched at the end of this cycle.
  - R_DATA: rvalid=1; rdata stays stable until rready.
- Read and write FSMs are independent and may run concurrently. If the read latch and the register write share an edge, the read returns the pre-write value.
- FND scan: a 0..SCAN_DIV-1 counter; on wrap the digit index advances 0→1→2→3→0.
  - fnd_com[idx]=0, all other bits 1.
  - fnd_seg = decode(nibble) with dp = ~mask[idx].
  - When fnd_en=0: fnd_com=4'hF, fnd_seg=8'hFF. The counter keeps running.
- Hex decode (g..a, active-low): 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0010000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110.

## Timing
- Reset (async assert, synchronous-release use): all registers 0, FSMs idle, scan counter and index 0.
  - awready, wready, bvalid, arready, rvalid = 0; bresp, rresp = 00; rdata = 0.
  - led = 0, fnd_com = 4'hF, fnd_seg = 8'hFF.
- Write latency: valids are seen in cycle N; awready/wready are high in N+1; bvalid is high in N+2; the led output updates in N+2.
- Read latency: arvalid is seen in cycle N; arready is high in N+1; rvalid and rdata are valid in N+2.
- Back-to-back: a new address is not accepted until the previous bvalid/rvalid handshake completes. Minimum 3 cycles per transaction with bready/rready tied high.
- Reset mid-transaction: outstanding responses are dropped immediately with no late bvalid/rvalid. A write whose W_ACK edge has not occurred does not modify the register.
- A digit slot lasts exactly SCAN_DIV cycles; a full frame lasts 4·SCAN_DIV cycles. Output changes are registered and update 1 cycle after the counter wrap.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back all four → rdata 0x1, 0x2, 0x3, 0x4, with every bresp/rresp = OKAY.
- Write 0xFFFFFFFF to 0xC, then write 0x12345678 with wstrb=4'b0101 → readback 0xFF34FF78.
- Write 0xA5 to 0x0 → led=0xA5 two cycles after the valids. Assert reset → led=0 asynchronously, with no clock edge needed.
- SCAN_DIV=4, REG_FND=0x00C1, REG_CTRL=0x21 → fnd_com cycles E, D, B, 7, every 4 clocks. Expected segments:
  - Digit 0: fnd_seg=0xF9.
  - Digit 1: fnd_seg=0x46 (C with dp on).
  - Digits 2 and 3: 0xC0.
  - Then REG_CTRL=0 → fnd_com=F, fnd_seg=FF.
- Hold bready=0 for 10 cycles after a write; issue awvalid only, no wvalid.
  - bvalid stays high with no second acceptance.
  - The lone awvalid never gets awready until wvalid arrives.
- Hold rready=0 for 10 cycles after a read, and write the same register during the hold → rdata stays at the old value and remains stable until rready.
